serial_subtractor: RTL and testbench

//  Bit-serial two's-complement subtractor: computes diff = a - b, LSB first, one bit per clock.
//  It is the inverse-direction counterpart of the team's ripple adder datapath.

---
 rtl/serial_subtractor_pkg.sv | 28 ++
 rtl/serial_subtractor_full_sub.sv | 36 +++
 rtl/serial_subtractor.sv | 183 ++++++++++++++++++
 tb/tb_serial_subtractor.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// ----------------------------------------------------------------------------
// serial_subtractor_pkg
// Shared definitions for the bit-serial subtractor:
//   - default operand width
//   - FSM state encoding (legacy constants plus a typed enum built on them)
//   - bit-counter width helper
// ----------------------------------------------------------------------------
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Raw encodings kept as plain constants so older code that compares
    // against literal state codes keeps working.
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE = S_IDLE,
        ST_RUN  = S_RUN
    } state_e;

    // Counter must be able to hold WIDTH (it increments once past the last
    // bit), hence clog2(WIDTH+1). Guard against a degenerate width.
    function automatic int cnt_width(input int w);
        return (w < 1) ? 1 : $clog2(w + 1);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_sub.sv
// ----------------------------------------------------------------------------
// full_sub
// 1-bit full subtractor computing x - y - bin, built from gate primitives.
// Ports:
//   x    in  minuend bit
//   y    in  subtrahend bit
//   bin  in  borrow in
//   d    out difference bit  = x ^ y ^ bin
//   bout out borrow out      = (~x & y) | (~(x ^ y) & bin)
// ----------------------------------------------------------------------------
module full_sub (
    input  wire x,
    input  wire y,
    input  wire bin,
    output wire d,
    output wire bout
);

    wire x_xor_y;
    wire x_n;
    wire xy_n;
    wire gen_b;   // borrow generated by this bit (x=0, y=1)
    wire prop_b;  // incoming borrow passed through (x == y)

    xor u_x0 (x_xor_y, x, y);
    xor u_x1 (d, x_xor_y, bin);

    not u_n0 (x_n, x);
    and u_a0 (gen_b, x_n, y);

    not u_n1 (xy_n, x_xor_y);
    and u_a1 (prop_b, xy_n, bin);

    or  u_o0 (bout, gen_b, prop_b);

endmodule

// File: rtl/serial_subtractor.sv
// ----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial two's-complement subtractor: diff = a - b, LSB first, one bit
// per clock, using a single full_sub cell.
// Parameters:
//   WIDTH       operand/result width (1..32)
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   start       in   request, only honoured while idle
//   a, b        in   operands, captured on an accepted start
//   busy        out  operation in progress
//   done        out  one-cycle pulse, results valid
//   diff        out  a - b mod 2^WIDTH, held until the next accepted start
//   borrow_out  out  unsigned borrow (a < b)
//   overflow    out  signed overflow of a - b
// ----------------------------------------------------------------------------
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int CW = cnt_width(WIDTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bin_q, bin_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             amsb_q, amsb_d;
    logic             bmsb_q, bmsb_d;
    logic             done_q, done_d;
    logic             bo_q, bo_d;
    logic             ov_q, ov_d;

    // ------------------------------------------------------------------
    // Bit cell
    // ------------------------------------------------------------------
    wire d_bit;
    wire bout_bit;

    full_sub u_fs (
        .x    (sa_q[0]),
        .y    (sb_q[0]),
        .bin  (bin_q),
        .d    (d_bit),
        .bout (bout_bit)
    );

    // Result register shifts right with the new bit entering at the MSB, so
    // after WIDTH shifts bit 0 of the result sits at diff[0].
    logic [WIDTH-1:0] diff_shift;

    generate
        if (WIDTH == 1) begin : g_shift_w1
            assign diff_shift = d_bit;
        end else begin : g_shift_wn
            assign diff_shift = {d_bit, diff_q[WIDTH-1:1]};
        end
    endgenerate

    logic last_bit;
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        diff_d  = diff_q;
        bin_d   = bin_q;
        cnt_d   = cnt_q;
        amsb_d  = amsb_q;
        bmsb_d  = bmsb_q;
        bo_d    = bo_q;
        ov_d    = ov_q;
        done_d  = 1'b0;       // done is a single-cycle pulse

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    sa_d    = a;
                    sb_d    = b;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    // Operand sign bits are kept aside because sa/sb are
                    // shifted away by the time the overflow flag is formed.
                    amsb_d  = a[WIDTH-1];
                    bmsb_d  = b[WIDTH-1];
                end
            end

            ST_RUN: begin
                diff_d = diff_shift;
                sa_d   = sa_q >> 1;
                sb_d   = sb_q >> 1;
                bin_d  = bout_bit;
                cnt_d  = cnt_q + 1'b1;
                if (last_bit) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    bo_d    = bout_bit;
                    // Signed overflow: operands of differing sign and the
                    // result sign differs from the minuend.
                    ov_d    = (amsb_q != bmsb_q) && (d_bit != amsb_q);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            diff_q  <= '0;
            bin_q   <= 1'b0;
            cnt_q   <= '0;
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
            done_q  <= 1'b0;
            bo_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            diff_q  <= diff_d;
            bin_q   <= bin_d;
            cnt_q   <= cnt_d;
            amsb_q  <= amsb_d;
            bmsb_q  <= bmsb_d;
            done_q  <= done_d;
            bo_q    <= bo_d;
            ov_q    <= ov_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy       = (state_q == ST_RUN);
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = bo_q;
    assign overflow   = ov_q;

    // ------------------------------------------------------------------
    // Internal consistency checks
    // ------------------------------------------------------------------
    a_done_idle : assert property (@(posedge clk) disable iff (!rst_n)
        done |-> !busy);

    a_cnt_range : assert property (@(posedge clk) disable iff (!rst_n)
        busy |-> (32'(cnt_q) < WIDTH));

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    typedef struct {
        logic [31:0] d;
        logic        bo;
        logic        ov;
    } res_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // WIDTH=8 instance (directed + random)
    logic        start8;
    logic [7:0]  a8, b8, diff8;
    logic        busy8, done8, bo8, ov8;
    // WIDTH=1 instance (random)
    logic        start1;
    logic [0:0]  a1, b1, diff1;
    logic        busy1, done1, bo1, ov1;
    // WIDTH=32 instance (random)
    logic        start32;
    logic [31:0] a32, b32, diff32;
    logic        busy32, done32, bo32, ov32;

    res_t q8[$];
    res_t q1[$];
    res_t q32[$];

    serial_subtractor #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8), .overflow(ov8));

    serial_subtractor #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1), .overflow(ov1));

    serial_subtractor #(.WIDTH(32)) u32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .diff(diff32), .borrow_out(bo32), .overflow(ov32));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain arithmetic on a w-bit field.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input int w);
        res_t        r;
        logic [31:0] m;
        m    = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        r.d  = (a - b) & m;
        r.bo = ((a & m) < (b & m));
        r.ov = (a[w-1] != b[w-1]) && (r.d[w-1] != a[w-1]);
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard monitors: pop and compare on each done pulse
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done8 === 1'b1) begin
            if (q8.size() == 0) chk("u8 spurious done", 32'(done8), 32'd0);
            else begin
                res_t e;
                e = q8.pop_front();
                chk("u8 diff", 32'(diff8), e.d);
                chk("u8 borrow_out", 32'(bo8), 32'(e.bo));
                chk("u8 overflow", 32'(ov8), 32'(e.ov));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && done1 === 1'b1) begin
            if (q1.size() == 0) chk("u1 spurious done", 32'(done1), 32'd0);
            else begin
                res_t e;
                e = q1.pop_front();
                chk("u1 diff", 32'(diff1), e.d);
                chk("u1 borrow_out", 32'(bo1), 32'(e.bo));
                chk("u1 overflow", 32'(ov1), 32'(e.ov));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && done32 === 1'b1) begin
            if (q32.size() == 0) chk("u32 spurious done", 32'(done32), 32'd0);
            else begin
                res_t e;
                e = q32.pop_front();
                chk("u32 diff", diff32, e.d);
                chk("u32 borrow_out", 32'(bo32), 32'(e.bo));
                chk("u32 overflow", 32'(ov32), 32'(e.ov));
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed single run on u8 with latency / pulse / hold checks
    // ------------------------------------------------------------------
    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] d, input logic bo, input logic ov);
        int n;
        @(negedge clk);
        a8 = a; b8 = b; start8 = 1'b1;
        q8.push_back('{d: 32'(d), bo: bo, ov: ov});
        @(negedge clk);                     // first negedge after E0
        start8 = 1'b0;
        chk("u8 busy after start", 32'(busy8), 32'd1);
        n = 0;
        while (done8 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("u8 latency", 32'(n), 32'd8);
        chk("u8 busy in done cycle", 32'(busy8), 32'd0);
        @(negedge clk);
        chk("u8 done width", 32'(done8), 32'd0);
        chk("u8 diff held", 32'(diff8), 32'(d));
    endtask

    task automatic rnd8();
        int   n;
        res_t e;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            a8 = 8'($urandom); b8 = 8'($urandom); start8 = 1'b1;
            e = model(32'(a8), 32'(b8), 8);
            q8.push_back(e);
            @(negedge clk);
            start8 = 1'b0;
            n = 0;
            while (done8 !== 1'b1 && n < 40) begin @(negedge clk); n++; end
            if (done8 !== 1'b1) chk("u8 random timeout", 32'(done8), 32'd1);
        end
    endtask

    task automatic rnd1();
        int   n;
        res_t e;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            a1 = 1'($urandom); b1 = 1'($urandom); start1 = 1'b1;
            e = model(32'(a1), 32'(b1), 1);
            q1.push_back(e);
            @(negedge clk);
            start1 = 1'b0;
            n = 0;
            while (done1 !== 1'b1 && n < 40) begin @(negedge clk); n++; end
            if (done1 !== 1'b1) chk("u1 random timeout", 32'(done1), 32'd1);
        end
    endtask

    task automatic rnd32();
        int   n;
        res_t e;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            a32 = $urandom; b32 = $urandom; start32 = 1'b1;
            e = model(a32, b32, 32);
            q32.push_back(e);
            @(negedge clk);
            start32 = 1'b0;
            n = 0;
            while (done32 !== 1'b1 && n < 60) begin @(negedge clk); n++; end
            if (done32 !== 1'b1) chk("u32 random timeout", 32'(done32), 32'd1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        vec_t tbl[8];
        int   n;

        tbl[0] = '{a: 8'h5A, b: 8'h3C, d: 8'h1E, bo: 1'b0, ov: 1'b0};
        tbl[1] = '{a: 8'h10, b: 8'h20, d: 8'hF0, bo: 1'b1, ov: 1'b0};
        tbl[2] = '{a: 8'h80, b: 8'h01, d: 8'h7F, bo: 1'b0, ov: 1'b1};
        tbl[3] = '{a: 8'h7F, b: 8'hFF, d: 8'h80, bo: 1'b1, ov: 1'b1};
        tbl[4] = '{a: 8'h00, b: 8'h01, d: 8'hFF, bo: 1'b1, ov: 1'b0};
        tbl[5] = '{a: 8'h7F, b: 8'h80, d: 8'hFF, bo: 1'b1, ov: 1'b1};
        tbl[6] = '{a: 8'hFF, b: 8'hFF, d: 8'h00, bo: 1'b0, ov: 1'b0};
        tbl[7] = '{a: 8'h80, b: 8'h7F, d: 8'h01, bo: 1'b0, ov: 1'b1};

        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start1 = 1'b0; a1 = '0; b1 = '0;
        start32 = 1'b0; a32 = '0; b32 = '0;

        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy8), 32'd0);
        chk("reset done", 32'(done8), 32'd0);
        chk("reset diff", 32'(diff8), 32'd0);
        chk("reset borrow_out", 32'(bo8), 32'd0);
        chk("reset overflow", 32'(ov8), 32'd0);
        rst_n = 1'b1;

        // Table-driven directed vectors
        for (int i = 0; i < 8; i++)
            run8(tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].bo, tbl[i].ov);

        // start held high through a run, operands changed mid-run; a second
        // start lands in the done cycle.
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h3C; start8 = 1'b1;
        q8.push_back('{d: 32'h1E, bo: 1'b0, ov: 1'b0});
        @(negedge clk);                     // n = 0, just after E0
        repeat (2) @(negedge clk);
        a8 = 8'h10; b8 = 8'h20;             // must not disturb the running op
        n = 2;
        while (done8 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("held-start latency", 32'(n), 32'd8);
        chk("held-start busy in done cycle", 32'(busy8), 32'd0);
        q8.push_back('{d: 32'hF0, bo: 1'b1, ov: 1'b0});
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                start8 = 1'b0;
                chk("restart busy", 32'(busy8), 32'd1);
                chk("restart done dropped", 32'(done8), 32'd0);
            end
        end while (done8 !== 1'b1 && n < 20);
        chk("done spacing", 32'(n), 32'd9);

        // Reset in the middle of a run
        @(negedge clk);
        a8 = 8'hC3; b8 = 8'h5A; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(busy8), 32'd0);
        chk("abort done", 32'(done8), 32'd0);
        chk("abort diff", 32'(diff8), 32'd0);
        chk("abort borrow_out", 32'(bo8), 32'd0);
        chk("abort overflow", 32'(ov8), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);         // any done here is flagged spurious
        chk("post-abort busy", 32'(busy8), 32'd0);
        run8(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

        // Random sweeps on all three widths in parallel
        fork
            rnd8();
            rnd1();
            rnd32();
        join
        repeat (3) @(negedge clk);

        chk("u8 scoreboard drained", 32'(q8.size()), 32'd0);
        chk("u1 scoreboard drained", 32'(q1.size()), 32'd0);
        chk("u32 scoreboard drained", 32'(q32.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
